// File: rtl/serial_arith_pkg.sv
// ============================================================================
// Module : serial_arith_pkg
// Brief  : Shared definitions for the bit-serial arithmetic cells: FSM state
//          encoding and a constant-foldable ceil(log2) helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // ceil(log2(value)); loop is bounded so it folds at elaboration.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_ha.sv
// ============================================================================
// Module : ha
// Brief  : Half adder, s = a ^ b, c = a & b. Two of these plus the carry
//          flip-flop in serial_adder form the per-bit full-add cell.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module : serial_adder
// Brief  : Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
//          Operands are captured on an accepted start; after WIDTH RUN cycles
//          the DONE state strobes done and {cout,sum} = a + b + cin is held
//          until the next accepted start.
//          Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting
//          a - b (cout then reads as NOT-borrow).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q,  a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,  b_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;

    logic               p_bit;   // a0 ^ b0
    logic               g1_bit;  // a0 & b0
    logic               s_bit;   // full-add sum bit
    logic               g2_bit;  // p & carry
    logic               c_bit;   // full-add carry out

    // Operand B and carry as they are loaded on an accepted start; in
    // subtract mode B is inverted and the carry forced to 1 (two's complement).
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b   : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    ha u_ha0 (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .s_o (p_bit),
        .c_o (g1_bit)
    );

    ha u_ha1 (
        .a_i (p_bit),
        .b_i (carry_q),
        .s_o (s_bit),
        .c_o (g2_bit)
    );

    assign c_bit = g1_bit | g2_bit;

    // State and datapath registers; reset clears everything, aborting any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and datapath: load on accepted start, shift one bit per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sr_d  = a;
                    b_sr_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d = c_bit;
                if (cnt_q == LAST_CNT) begin
                    cout_d  = c_bit;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module : tb_serial_adder
// Brief  : Directed self-checking bench for serial_adder (WIDTH = 8), plus
//          random operands checked against a + b + cin.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks;
    int n_errors;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high for exactly one accepting edge.
    task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for done; records a failed check if it never arrives.
    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (done !== 1'b1) check({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    logic [WIDTH:0]   exp_res;
    logic [WIDTH-1:0] ra, rb;
    logic             rc;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: 5A + 3C, busy for exactly WIDTH cycles, then done
        launch(8'h5A, 8'h3C, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            check("t1_busy", 32'(busy), 32'd1);
            check("t1_nodone", 32'(done), 32'd0);
            tick();
        end
        check("t1_done",  32'(done), 32'd1);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_res",   32'({cout, sum}), 32'h096);
        tick();
        check("t1_strobe", 32'(done), 32'd0);
        check("t1_hold",  32'({cout, sum}), 32'h096);

        // 2: FF + 01, then back-to-back FF + FF + 1 started during DONE
        launch(8'hFF, 8'h01, 1'b0);
        wait_done("t2a");
        check("t2a_res", 32'({cout, sum}), 32'h100);
        launch(8'hFF, 8'hFF, 1'b1);
        check("t2_noidle", 32'(busy), 32'd1);
        check("t2_cleared", 32'({cout, sum}), 32'h000);
        wait_done("t2b");
        check("t2b_res", 32'({cout, sum}), 32'h1FF);
        tick();

        // 3: start during RUN is ignored
        launch(8'h12, 8'h34, 1'b0);
        tick();
        tick();
        launch(8'hFF, 8'hFF, 1'b1);
        check("t3_busy", 32'(busy), 32'd1);
        wait_done("t3");
        check("t3_res", 32'({cout, sum}), 32'h046);
        tick();

        // 4: asynchronous reset in RUN cycle 4 aborts the operation
        launch(8'hFF, 8'h00, 1'b1);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_done", 32'(done), 32'd0);
        check("t4_res",  32'({cout, sum}), 32'h000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 3; i++) begin
            tick();
            check("t4_idle_done", 32'(done), 32'd0);
            check("t4_idle_busy", 32'(busy), 32'd0);
        end

        // 5: random operands against a + b + cin, result held while idle
        for (int n = 0; n < 1000; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            exp_res = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            launch(ra, rb, rc);
            wait_done("t5");
            check("t5_res", 32'({cout, sum}), 32'(exp_res));
            a = ~ra;
            b = ~rb;
            for (int k = 0; k < 5; k++) begin
                tick();
                check("t5_hold", 32'({cout, sum}), 32'(exp_res));
            end
        end

`ifdef SERIAL_ADDER_SUB_EN
        // 6: subtraction mode
        sub = 1'b1;
        launch(8'h10, 8'h20, 1'b0);
        wait_done("t6a");
        check("t6a_res", 32'({cout, sum}), 32'h0F0);
        tick();
        launch(8'h20, 8'h10, 1'b0);
        wait_done("t6b");
        check("t6b_res", 32'({cout, sum}), 32'h110);
        tick();
        sub = 1'b0;
        launch(8'h20, 8'h10, 1'b0);
        wait_done("t6c");
        check("t6c_res", 32'({cout, sum}), 32'h030);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
